// File: rtl/exp6_unidade_controle_rodadas.sv
// Purpose : Moore control unit sequencing the multi-round memory-game datapath,
//           with an inactivity timer that ends the game when no play arrives.
// Latency : iniciar -> espera in 3 edges; jogada -> comparacao in 2 edges.
// Backpr. : none; jogada is a single-cycle pulse honoured only in espera, other
//           inputs are level-sampled and ignored in states that do not use them.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   iniciar                start / restart request (inicial and final states)
//   jogada                 one-cycle pulse: a play is available
//   igual                  stored play matches memory entry at address E
//   fim_jogada             address counter E reached round limit L
//   fim_rodada             round limit L reached the last round
//   zeraE/contaE           address counter controls
//   zeraL/contaL           round-limit counter controls
//   zeraR/registraR        play register controls
//   acertou/errou/timeout  game outcome flags (one-hot while pronto)
//   pronto                 game finished, any outcome
//   db_estado              current state code for debug displays

module exp6_unidade_controle_rodadas #(
    parameter int TIMEOUT_CICLOS = 3000,
    parameter int TW             = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fim_jogada,
    input  logic       fim_rodada,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    // State codes double as the debug display value, so they are fixed.
    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_A          = 4'hA,
        FIM_T          = 4'hD,
        FIM_E          = 4'hE
    } estado_t;

    // Last timer value seen in espera before the window closes.
    localparam logic [TW-1:0] TIMER_LIM = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [TW-1:0] TIMER_UM  = TW'(1);

    estado_t         estado_q;
    estado_t         estado_d;
    logic [TW-1:0]   timer_q;
    logic [TW-1:0]   timer_d;
    logic            timer_expirou;

    // ------------------------------------------------------------------
    // State and timer registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            timer_q  <= timer_d;
        end
    end

    assign timer_expirou = (timer_q == TIMER_LIM);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO: begin
                estado_d = INICIO_RODADA;
            end
            INICIO_RODADA: begin
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A play arriving on the last timer cycle still counts.
                if (jogada)             estado_d = REGISTRA;
                else if (timer_expirou) estado_d = FIM_T;
            end
            REGISTRA: begin
                estado_d = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual)          estado_d = FIM_E;
                else if (!fim_jogada) estado_d = PROXIMA_JOGADA;
                else if (!fim_rodada) estado_d = PROXIMA_RODADA;
                else                  estado_d = FIM_A;
            end
            PROXIMA_JOGADA: begin
                estado_d = ESPERA;
            end
            PROXIMA_RODADA: begin
                // Going back through inicio_rodada re-zeroes address E.
                estado_d = INICIO_RODADA;
            end
            FIM_A, FIM_E, FIM_T: begin
                // Restart skips inicial: preparacao clears everything anyway.
                if (iniciar) estado_d = PREPARACAO;
            end
            default: begin
                estado_d = INICIAL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Inactivity timer: counts only across consecutive espera cycles, so
    // every play starts with a fresh window and registra sees zero.
    // ------------------------------------------------------------------
    always_comb begin
        timer_d = '0;
        if ((estado_q == ESPERA) && (estado_d == ESPERA)) begin
            timer_d = timer_q + TIMER_UM;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = 4'hF;
        unique case (estado_q)
            INICIAL, PREPARACAO: begin
                zeraE     = 1'b1;
                zeraL     = 1'b1;
                zeraR     = 1'b1;
                db_estado = estado_q;
            end
            INICIO_RODADA: begin
                zeraE     = 1'b1;
                db_estado = estado_q;
            end
            ESPERA, COMPARACAO: begin
                db_estado = estado_q;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = estado_q;
            end
            PROXIMA_JOGADA: begin
                contaE    = 1'b1;
                db_estado = estado_q;
            end
            PROXIMA_RODADA: begin
                contaL    = 1'b1;
                db_estado = estado_q;
            end
            FIM_A: begin
                acertou   = 1'b1;
                db_estado = estado_q;
            end
            FIM_E: begin
                errou     = 1'b1;
                db_estado = estado_q;
            end
            FIM_T: begin
                timeout   = 1'b1;
                db_estado = estado_q;
            end
            default: begin
                db_estado = 4'hF;
            end
        endcase
    end

    assign pronto = acertou | errou | timeout;

endmodule

// File: tb/tb_exp6_unidade_controle_rodadas.sv
// Purpose : directed self-checking bench for the round control unit.
// Latency : one expectation queued per clock edge, checked 1 time unit later.
// Backpr. : none; stimulus is a fixed linear sequence.

module tb_exp6_unidade_controle_rodadas;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       fim_jogada;
    logic       fim_rodada;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;

    int tests = 0;
    int fails = 0;

    // Scoreboard: expected {state, outputs} pushed before each edge.
    string       tag_q[$];
    logic [13:0] sb_q[$];

    exp6_unidade_controle_rodadas #(
        .TIMEOUT_CICLOS(8),
        .TW(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .jogada(jogada),
        .igual(igual),
        .fim_jogada(fim_jogada),
        .fim_rodada(fim_rodada),
        .zeraE(zeraE),
        .contaE(contaE),
        .zeraL(zeraL),
        .contaL(contaL),
        .zeraR(zeraR),
        .registraR(registraR),
        .acertou(acertou),
        .errou(errou),
        .timeout(timeout),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Output table per state:
    // {zeraE,contaE,zeraL,contaL,zeraR,registraR,acertou,errou,timeout,pronto}
    function automatic logic [9:0] saidas_esperadas(input logic [3:0] st);
        logic [9:0] o;
        case (st)
            4'h0, 4'h1: o = 10'b1_0_1_0_1_0_0_0_0_0;
            4'h2:       o = 10'b1_0_0_0_0_0_0_0_0_0;
            4'h4:       o = 10'b0_0_0_0_0_1_0_0_0_0;
            4'h6:       o = 10'b0_1_0_0_0_0_0_0_0_0;
            4'h7:       o = 10'b0_0_0_1_0_0_0_0_0_0;
            4'hA:       o = 10'b0_0_0_0_0_0_1_0_0_1;
            4'hE:       o = 10'b0_0_0_0_0_0_0_1_0_1;
            4'hD:       o = 10'b0_0_0_0_0_0_0_0_1_1;
            default:    o = 10'b0;
        endcase
        return o;
    endfunction

    // Queue the expectation, clock once, then pop and compare away from the edge.
    task automatic tick(input string tag, input logic [3:0] st_exp);
        logic [13:0] e;
        logic [9:0]  obs_o;
        string       t;
        tag_q.push_back(tag);
        sb_q.push_back({st_exp, saidas_esperadas(st_exp)});
        @(posedge clock);
        #1;
        t = tag_q.pop_front();
        e = sb_q.pop_front();
        obs_o = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                 acertou, errou, timeout, pronto};
        tests++;
        assert (db_estado === e[13:10]) else begin
            fails++;
            $error("FAIL %s db_estado observed=%h expected=%h", t, db_estado, e[13:10]);
        end
        tests++;
        assert (obs_o === e[9:0]) else begin
            fails++;
            $error("FAIL %s outputs observed=%b expected=%b", t, obs_o, e[9:0]);
        end
    endtask

    initial begin
        reset      = 1'b1;
        iniciar    = 1'b0;
        jogada     = 1'b0;
        igual      = 1'b0;
        fim_jogada = 1'b0;
        fim_rodada = 1'b0;

        // Reset and start
        tick("reset", 4'h0);
        reset = 1'b0;
        tick("idle", 4'h0);
        iniciar = 1'b1;
        tick("preparacao", 4'h1);
        iniciar = 1'b0;
        tick("inicio_rodada", 4'h2);
        tick("espera", 4'h3);

        // Round 0: single correct play, not last round
        jogada = 1'b1; igual = 1'b1; fim_jogada = 1'b1; fim_rodada = 1'b0;
        tick("r0_registra", 4'h4);
        jogada = 1'b0;
        tick("r0_comparacao", 4'h5);
        tick("r0_proxima_rodada", 4'h7);
        tick("r1_inicio_rodada", 4'h2);
        tick("r1_espera", 4'h3);

        // Round 1: first play not end of round
        fim_jogada = 1'b0;
        jogada = 1'b1;
        tick("r1p0_registra", 4'h4);
        jogada = 1'b0;
        tick("r1p0_comparacao", 4'h5);
        tick("r1p0_proxima_jogada", 4'h6);
        tick("r1p1_espera", 4'h3);

        // Round 1: last play of last round -> win
        fim_jogada = 1'b1; fim_rodada = 1'b1;
        jogada = 1'b1;
        tick("r1p1_registra", 4'h4);
        jogada = 1'b0;
        tick("r1p1_comparacao", 4'h5);
        tick("fim_A", 4'hA);
        // jogada in a final state is ignored
        jogada = 1'b1;
        tick("fim_A_hold_jogada", 4'hA);
        jogada = 1'b0;
        tick("fim_A_hold", 4'hA);

        // Restart from A without passing through inicial
        iniciar = 1'b1;
        tick("restart_A", 4'h1);
        iniciar = 1'b0;
        tick("restart_A_ini", 4'h2);
        tick("restart_A_esp", 4'h3);

        // Wrong play in round 0
        igual = 1'b0; fim_jogada = 1'b1; fim_rodada = 1'b0;
        jogada = 1'b1;
        tick("err_registra", 4'h4);
        jogada = 1'b0;
        tick("err_comparacao", 4'h5);
        tick("fim_E", 4'hE);
        for (int i = 0; i < 20; i++) tick("fim_E_hold", 4'hE);

        // Restart from E, then let the timer expire
        iniciar = 1'b1;
        tick("restart_E", 4'h1);
        iniciar = 1'b0;
        tick("restart_E_ini", 4'h2);
        tick("to_espera", 4'h3);
        for (int i = 0; i < 7; i++) tick("to_wait", 4'h3);
        tick("fim_T", 4'hD);
        tick("fim_T_hold", 4'hD);

        // Restart from D; jogada exactly on the last timer cycle wins
        iniciar = 1'b1;
        tick("restart_T", 4'h1);
        iniciar = 1'b0;
        tick("restart_T_ini", 4'h2);
        tick("edge_espera", 4'h3);
        for (int i = 0; i < 7; i++) tick("edge_wait", 4'h3);
        igual = 1'b1; fim_jogada = 1'b1; fim_rodada = 1'b0;
        jogada = 1'b1;
        tick("edge_jogada_wins", 4'h4);
        jogada = 1'b0;
        tick("edge_comparacao", 4'h5);
        tick("edge_proxima_rodada", 4'h7);
        tick("rf_inicio_rodada", 4'h2);
        tick("rf_espera0", 4'h3);

        // Timer refresh: two long waits in a row, neither times out
        fim_jogada = 1'b0;
        for (int i = 0; i < 7; i++) tick("rf_wait0", 4'h3);
        jogada = 1'b1;
        tick("rf_registra0", 4'h4);
        jogada = 1'b0;
        tick("rf_comparacao0", 4'h5);
        tick("rf_proxima_jogada", 4'h6);
        tick("rf_espera1", 4'h3);
        fim_jogada = 1'b1; fim_rodada = 1'b1;
        for (int i = 0; i < 7; i++) tick("rf_wait1", 4'h3);
        jogada = 1'b1;
        tick("rf_registra1", 4'h4);
        jogada = 1'b0;
        tick("rf_comparacao1", 4'h5);
        tick("rf_fim_A", 4'hA);

        // Reset wins over iniciar in a final state
        reset = 1'b1; iniciar = 1'b1;
        tick("reset_over_iniciar", 4'h0);
        reset = 1'b0; iniciar = 1'b0;
        tick("idle_after_reset", 4'h0);

        // Reset mid-round while in registra
        iniciar = 1'b1;
        tick("mid_preparacao", 4'h1);
        iniciar = 1'b0;
        tick("mid_inicio_rodada", 4'h2);
        tick("mid_espera", 4'h3);
        jogada = 1'b1;
        tick("mid_registra", 4'h4);
        jogada = 1'b0;
        reset = 1'b1;
        tick("reset_in_registra", 4'h0);
        reset = 1'b0;
        tick("idle_final", 4'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
